// File: rtl/rv32i_pkg.sv
// Shared RV32I load/store encodings, LSU FSM states and fault codes.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ALIGN   = 2'b01;
  localparam logic [1:0] FC_BUS_ERR = 2'b10;
  localparam logic [1:0] FC_TIMEOUT = 2'b11;

  // Illegal width code for the direction, or an address not aligned to the access size.
  function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:  bad = 1'b0;
      F3_H:  bad = off[0];
      F3_W:  bad = (off != 2'b00);
      F3_BU: bad = we;
      F3_HU: bad = we | off[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] sel;
    case (f3[1:0])
      2'b00:   sel = 4'b0001 << off;
      2'b01:   sel = 4'b0011 << off;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a bus word and sign- or zero-extends it.
module lsu_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_data[7:0];
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      default: w_byte = i_data[31:24];
    endcase
    w_half = i_off[1] ? i_data[31:16] : i_data[15:0];
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'b0, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'b0, w_half};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/lsu_wb.sv
// RV32I load/store unit driving a Wishbone classic master port.
// Optional bus-wait timeout is built when LSU_WB_TIMEOUT_EN is defined.
module lsu_wb
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [1:0]  dbg_state
);

  lsu_state_e  r_state, w_next;
  logic        r_we, r_fault;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_wdata, r_ldata;
  logic [4:0]  r_rd;
  logic [1:0]  r_cause;
  logic        w_accept, w_bad, w_timeout, w_bus_done, w_wr;
  logic [31:0] w_ldata, w_wdat_rep;

  // A request transfers on a rising edge where req_valid && req_ready; req_ready is
  // high exactly in IDLE and does not depend on req_valid.
  assign w_accept   = (r_state == ST_IDLE) && req_valid;
  assign w_bad      = req_bad(req_we, req_funct3, req_addr[1:0]);
  assign dbg_state  = r_state;

`ifdef LSU_WB_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    r_tmo_cnt <= 16'd0;
    else if (r_state != ST_BUS) r_tmo_cnt <= 16'd0;
    else                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end

  assign w_timeout = (r_state == ST_BUS) && !wb_ack_i && !wb_err_i &&
                     (r_tmo_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_bus_done = wb_ack_i || wb_err_i || w_timeout;

  lsu_load_align u_align (
    .i_data   (wb_dat_i),
    .i_off    (r_addr[1:0]),
    .i_funct3 (r_funct3),
    .o_data   (w_ldata)
  );

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_wdat_rep = {4{r_wdata[7:0]}};
      2'b01:   w_wdat_rep = {2{r_wdata[15:0]}};
      default: w_wdat_rep = r_wdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = w_bad ? ST_RESP : ST_BUS;
      ST_BUS:  if (w_bus_done) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_funct3 <= 3'b0;
      r_addr   <= 32'b0;
      r_wdata  <= 32'b0;
      r_rd     <= 5'b0;
      r_ldata  <= 32'b0;
      r_fault  <= 1'b0;
      r_cause  <= FC_NONE;
    end else if (w_accept) begin
      r_we     <= req_we;
      r_funct3 <= req_funct3;
      r_addr   <= req_addr;
      r_wdata  <= req_wdata;
      r_rd     <= req_rd;
      r_fault  <= w_bad;
      r_cause  <= w_bad ? FC_ALIGN : FC_NONE;
    end else if ((r_state == ST_BUS) && w_bus_done) begin
      r_ldata <= w_ldata;
      // err outranks a simultaneous ack; no ack and no err here means timeout
      if (wb_err_i) begin
        r_fault <= 1'b1;
        r_cause <= FC_BUS_ERR;
      end else if (!wb_ack_i) begin
        r_fault <= 1'b1;
        r_cause <= FC_TIMEOUT;
      end
    end
  end

  always_comb begin
    req_ready   = (r_state == ST_IDLE);
    busy        = (r_state != ST_IDLE);
    wb_cyc_o    = 1'b0;
    wb_stb_o    = 1'b0;
    wb_we_o     = 1'b0;
    wb_adr_o    = 32'b0;
    wb_dat_o    = 32'b0;
    wb_sel_o    = 4'b0;
    w_wr        = 1'b0;
    rf_we       = 1'b0;
    rf_wa       = 5'b0;
    rf_wd       = 32'b0;
    fault       = 1'b0;
    fault_cause = FC_NONE;
    case (r_state)
      ST_BUS: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
        wb_we_o  = r_we;
        wb_adr_o = {r_addr[31:2], 2'b00};
        wb_sel_o = lane_sel(r_funct3, r_addr[1:0]);
        wb_dat_o = r_we ? w_wdat_rep : 32'b0;
      end
      ST_RESP: begin
        w_wr        = !r_fault && !r_we && (r_rd != 5'd0);
        rf_we       = w_wr;
        rf_wa       = w_wr ? r_rd : 5'b0;
        rf_wd       = w_wr ? r_ldata : 32'b0;
        fault       = r_fault;
        fault_cause = r_fault ? r_cause : FC_NONE;
      end
      default: ;
    endcase
  end

endmodule
